// File: rtl/issue_queue_rs_pkg.sv
// Shared micro-architecture types for the reservation stations: instruction payload,
// CDB writeback packet and the operand wakeup helper.
package issue_queue_rs_pkg;

  localparam int unsigned PIPE_WIDTH         = 2;
  localparam int unsigned RS_ENTRIES_DEFAULT = 8;
  localparam int unsigned TAG_W              = 6;
  localparam int unsigned XLEN               = 32;
  localparam int unsigned OPC_W              = 8;

  typedef struct packed {
    logic             is_renamed;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } operand_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [TAG_W-1:0] dest_tag;
    operand_t         src_0_a;
    operand_t         src_0_b;
  } instruction_t;

  typedef struct packed {
    logic             is_valid;
    logic [TAG_W-1:0] dest_tag;
    logic [XLEN-1:0]  result;
  } writeback_packet_t;

  // Capture a CDB result into a waiting operand; ports are walked high to low so
  // that port 0 has the last word when two ports carry the same tag.
  function automatic operand_t operand_wakeup(operand_t op,
                                              writeback_packet_t [PIPE_WIDTH-1:0] cdb);
    operand_t res;
    res = op;
    for (int p = int'(PIPE_WIDTH) - 1; p >= 0; p--) begin
      if (op.is_renamed && cdb[p].is_valid && (cdb[p].dest_tag == op.tag)) begin
        res.is_renamed = 1'b0;
        res.data       = cdb[p].result;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/issue_queue_rs_age_select.sv
// Age matrix plus oldest-ready picker. Row i holds a 1 in column j when entry j is
// older than entry i.
module rs_age_select #(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic [NUM_ENTRIES-1:0] i_valid,
  input  logic [NUM_ENTRIES-1:0] i_ready,
  input  logic [NUM_ENTRIES-1:0] i_free_oh,
  input  logic [NUM_ENTRIES-1:0] i_alloc0_oh,
  input  logic [NUM_ENTRIES-1:0] i_alloc1_oh,
  output logic [NUM_ENTRIES-1:0] o_grant_oh
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_age;
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] w_age_d;

  // Next age rows: new entries see every currently valid entry (and the same-cycle
  // channel-0 entry) as older; a freed entry's column is cleared everywhere.
  always_comb begin
    w_age_d = r_age;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      w_age_d[i] = r_age[i] & ~i_free_oh;
      if (i_alloc0_oh[i]) w_age_d[i] = i_valid & ~i_free_oh;
      if (i_alloc1_oh[i]) w_age_d[i] = (i_valid | i_alloc0_oh) & ~i_free_oh;
      if (i_flush)        w_age_d[i] = '0;
    end
  end

  // Age matrix register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_age <= '0;
    else        r_age <= w_age_d;
  end

  // An entry wins when no ready entry is older than it; ages are a total order, so
  // at most one bit is set.
  always_comb begin
    o_grant_oh = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      o_grant_oh[i] = i_ready[i] && ((r_age[i] & i_ready) == '0);
    end
  end

endmodule

// File: rtl/issue_queue_rs.sv
// Reservation station: accepts dispatched instructions, captures CDB results and
// issues the oldest fully-ready entry to one execution unit.
module issue_queue_rs
  import issue_queue_rs_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = RS_ENTRIES_DEFAULT  // must be >= PIPE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  output logic              [PIPE_WIDTH-1:0]   rs_rdy,
  input  logic              [PIPE_WIDTH-1:0]   rs_we,
  input  instruction_t      [PIPE_WIDTH-1:0]   rs_issue_port,
  input  writeback_packet_t [PIPE_WIDTH-1:0]   cdb,
  output logic                                 issue_valid,
  input  logic                                 issue_rdy,
  output instruction_t                         issue_inst
);

  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  logic                                    [NUM_ENTRIES-1:0] r_valid;
  instruction_t                            [NUM_ENTRIES-1:0] r_entry;
  logic                                    [CNT_W-1:0]       r_free_cnt;

  logic                                    [NUM_ENTRIES-1:0] w_valid_d;
  instruction_t                            [NUM_ENTRIES-1:0] w_entry_d;
  logic                                    [CNT_W-1:0]       w_free_cnt_d;
  logic                                    [NUM_ENTRIES-1:0] w_ready;
  logic                                    [NUM_ENTRIES-1:0] w_grant;
  logic                                    [NUM_ENTRIES-1:0] w_free_oh;
  logic [PIPE_WIDTH-1:0]                   [NUM_ENTRIES-1:0] w_alloc_oh;
  logic                                    [CNT_W-1:0]       w_n_alloc;
  logic                                                      w_fire;

  // Readiness decoded only from the registered free count.
  always_comb begin
    rs_rdy = '0;
    for (int k = 0; k < int'(PIPE_WIDTH); k++) begin
      rs_rdy[k] = (r_free_cnt >= CNT_W'(k + 1));
    end
  end

  // Slot allocation from the start-of-cycle free map: each enabled channel takes the
  // lowest remaining free index, channel 0 first. A write with nothing free is dropped.
  always_comb begin
    logic [NUM_ENTRIES-1:0] avail;
    logic                   found;
    avail      = ~r_valid;
    w_n_alloc  = '0;
    w_alloc_oh = '0;
    for (int k = 0; k < int'(PIPE_WIDTH); k++) begin
      found = 1'b0;
      if (rs_we[k]) begin
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
          if (!found && avail[i]) begin
            w_alloc_oh[k][i] = 1'b1;
            found            = 1'b1;
          end
        end
      end
      avail = avail & ~w_alloc_oh[k];
      if (found) w_n_alloc = w_n_alloc + CNT_W'(1);
    end
  end

  // Entry is ready once both operands have been resolved.
  always_comb begin
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      w_ready[i] = r_valid[i] && !r_entry[i].src_0_a.is_renamed
                              && !r_entry[i].src_0_b.is_renamed;
    end
  end

  rs_age_select #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_age_select (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_valid     (r_valid),
    .i_ready     (w_ready),
    .i_free_oh   (w_free_oh),
    .i_alloc0_oh (w_alloc_oh[0]),
    .i_alloc1_oh (w_alloc_oh[1]),
    .o_grant_oh  (w_grant)
  );

  // Issue mux: grant is one-hot, so the selected entry drives issue_inst unchanged.
  always_comb begin
    issue_inst = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (w_grant[i]) issue_inst = r_entry[i];
    end
  end

  assign issue_valid = |w_grant;
  assign w_fire      = issue_valid && issue_rdy;
  assign w_free_oh   = w_grant & {NUM_ENTRIES{w_fire}};

  // Entry next state: wakeup of resident entries, free on issue, write with CDB
  // bypass, and flush overriding everything.
  always_comb begin
    w_valid_d = r_valid;
    w_entry_d = r_entry;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (r_valid[i]) begin
        w_entry_d[i].src_0_a = operand_wakeup(r_entry[i].src_0_a, cdb);
        w_entry_d[i].src_0_b = operand_wakeup(r_entry[i].src_0_b, cdb);
      end
      if (w_free_oh[i]) w_valid_d[i] = 1'b0;
      for (int k = 0; k < int'(PIPE_WIDTH); k++) begin
        if (w_alloc_oh[k][i]) begin
          w_valid_d[i]         = 1'b1;
          w_entry_d[i]         = rs_issue_port[k];
          w_entry_d[i].src_0_a = operand_wakeup(rs_issue_port[k].src_0_a, cdb);
          w_entry_d[i].src_0_b = operand_wakeup(rs_issue_port[k].src_0_b, cdb);
        end
      end
    end
    if (flush) w_valid_d = '0;
  end

  // Freed slots are counted back in while this cycle's writes are taken out.
  always_comb begin
    if (flush) w_free_cnt_d = CNT_W'(NUM_ENTRIES);
    else       w_free_cnt_d = r_free_cnt - w_n_alloc + {{(CNT_W-1){1'b0}}, w_fire};
  end

  // Entry state and free count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_entry    <= '0;
      r_free_cnt <= CNT_W'(NUM_ENTRIES);
    end else begin
      r_valid    <= w_valid_d;
      r_entry    <= w_entry_d;
      r_free_cnt <= w_free_cnt_d;
    end
  end

  // Dispatch must never write more entries than are free.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(rs_we) <= int'(r_free_cnt));

  // Two CDB ports carrying the same tag is suspicious; port 0 wins.
  for (genvar p = 0; p < int'(PIPE_WIDTH); p++) begin : g_cdb_p
    for (genvar q = p + 1; q < int'(PIPE_WIDTH); q++) begin : g_cdb_q
      a_cdb_unique: assert property (@(posedge clk) disable iff (!rst_n)
        !(cdb[p].is_valid && cdb[q].is_valid && (cdb[p].dest_tag == cdb[q].dest_tag)))
        else $warning("duplicate CDB tag on two ports");
    end
  end

endmodule

// File: tb/tb_issue_queue_rs.sv
// Self-checking bench for issue_queue_rs: directed scenarios plus randomized traffic,
// checked every cycle against a slot/age-stamp model of the station.
module tb_issue_queue_rs;
  import issue_queue_rs_pkg::*;

  localparam int N = 8;

  logic                                 clk = 1'b0;
  logic                                 rst_n = 1'b0;
  logic                                 flush;
  logic              [PIPE_WIDTH-1:0]   rs_rdy;
  logic              [PIPE_WIDTH-1:0]   rs_we;
  instruction_t      [PIPE_WIDTH-1:0]   port;
  writeback_packet_t [PIPE_WIDTH-1:0]   cdb;
  logic                                 issue_valid;
  logic                                 issue_rdy;
  instruction_t                         issue_inst;

  issue_queue_rs #(
    .NUM_ENTRIES (N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .rs_rdy        (rs_rdy),
    .rs_we         (rs_we),
    .rs_issue_port (port),
    .cdb           (cdb),
    .issue_valid   (issue_valid),
    .issue_rdy     (issue_rdy),
    .issue_inst    (issue_inst)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: slots with an allocation sequence number; oldest = smallest stamp.
  bit           m_valid [N];
  instruction_t m_inst  [N];
  int           m_stamp [N];
  int           m_seq;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic operand_t mk_op(input bit ren, input int tag, input logic [31:0] data);
    operand_t o;
    o.is_renamed = ren;
    o.tag        = TAG_W'(tag);
    o.data       = data;
    return o;
  endfunction

  function automatic instruction_t mk_inst(input int opc, input operand_t a, input operand_t b);
    instruction_t x;
    x.opcode   = OPC_W'(opc);
    x.dest_tag = TAG_W'(opc);
    x.src_0_a  = a;
    x.src_0_b  = b;
    return x;
  endfunction

  function automatic operand_t m_wake(input operand_t op,
                                      input writeback_packet_t [PIPE_WIDTH-1:0] c);
    operand_t o;
    o = op;
    if (!o.is_renamed) return o;
    for (int p = 0; p < PIPE_WIDTH; p++) begin
      if (c[p].is_valid && c[p].dest_tag == o.tag) begin
        o.is_renamed = 1'b0;
        o.data       = c[p].result;
        return o;
      end
    end
    return o;
  endfunction

  function automatic int m_pick();
    int best;
    best = -1;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && !m_inst[i].src_0_a.is_renamed && !m_inst[i].src_0_b.is_renamed) begin
        if (best < 0 || m_stamp[i] < m_stamp[best]) best = i;
      end
    end
    return best;
  endfunction

  function automatic int m_free();
    int f;
    f = 0;
    for (int i = 0; i < N; i++) if (!m_valid[i]) f++;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_inst[i]  = '0;
      m_stamp[i] = 0;
    end
    m_seq = 0;
  endtask

  // Applies one clock edge of the current inputs to the model.
  task automatic model_update();
    bit pre   [N];
    bit taken [N];
    int sel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      return;
    end
    sel = m_pick();
    for (int i = 0; i < N; i++) begin
      pre[i]   = m_valid[i];
      taken[i] = 1'b0;
      if (m_valid[i]) begin
        m_inst[i].src_0_a = m_wake(m_inst[i].src_0_a, cdb);
        m_inst[i].src_0_b = m_wake(m_inst[i].src_0_b, cdb);
      end
    end
    if (sel >= 0 && issue_rdy) m_valid[sel] = 1'b0;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      if (rs_we[k]) begin
        for (int i = 0; i < N; i++) begin
          if (!pre[i] && !taken[i]) begin
            taken[i]          = 1'b1;
            m_valid[i]        = 1'b1;
            m_inst[i]         = port[k];
            m_inst[i].src_0_a = m_wake(port[k].src_0_a, cdb);
            m_inst[i].src_0_b = m_wake(port[k].src_0_b, cdb);
            m_stamp[i]        = m_seq++;
            break;
          end
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int          sel;
    int          fr;
    logic [1:0]  er;
    if (chk_en && rst_n) begin
      sel   = m_pick();
      fr    = m_free();
      er[0] = (fr >= 1);
      er[1] = (fr >= 2);
      check("rs_rdy", 128'(rs_rdy), 128'(er));
      check("issue_valid", 128'(issue_valid), 128'(sel >= 0));
      if (sel >= 0) check("issue_inst", 128'(issue_inst), 128'(m_inst[sel]));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rs_we = '0;
    port  = '0;
    cdb   = '0;
    flush = 1'b0;
  endtask

  function automatic instruction_t rand_inst();
    return mk_inst($urandom_range(0, 255),
                   mk_op($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom),
                   mk_op($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom));
  endfunction

  initial begin
    int t0;
    int we;
    idle_inputs();
    issue_rdy = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("reset_rs_rdy", 128'(rs_rdy), 128'(2'b11));
    check("reset_issue_valid", 128'(issue_valid), 128'(1'b0));
    check("reset_issue_inst", 128'(issue_inst), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Two ready instructions: ch0 issues first, then ch1
    issue_rdy = 1'b1;
    port[0] = mk_inst(8'h11, mk_op(0, 0, 32'h1), mk_op(0, 0, 32'h2));
    port[1] = mk_inst(8'h22, mk_op(0, 0, 32'h3), mk_op(0, 0, 32'h4));
    rs_we   = 2'b11;
    tick();
    idle_inputs();
    check("pair_first", 128'(issue_inst.opcode), 128'(8'h11));
    tick();
    check("pair_second", 128'(issue_inst.opcode), 128'(8'h22));
    tick();
    check("pair_drained_valid", 128'(issue_valid), 128'(1'b0));
    check("pair_drained_rdy", 128'(rs_rdy), 128'(2'b11));

    // Waiting operand woken by cdb[1] two cycles later
    port[0] = mk_inst(8'h33, mk_op(1, 5, 0), mk_op(0, 0, 32'h1234));
    rs_we   = 2'b01;
    tick();
    idle_inputs();
    check("wait_not_ready", 128'(issue_valid), 128'(1'b0));
    tick();
    cdb[1] = '{is_valid: 1'b1, dest_tag: 6'd5, result: 32'hDEAD};
    tick();
    idle_inputs();
    check("wake_valid", 128'(issue_valid), 128'(1'b1));
    check("wake_data", 128'(issue_inst.src_0_a.data), 128'(32'hDEAD));
    tick();

    // Same-cycle CDB bypass into the written entry
    port[0] = mk_inst(8'h44, mk_op(1, 9, 0), mk_op(1, 10, 0));
    cdb[0]  = '{is_valid: 1'b1, dest_tag: 6'd9,  result: 32'hBEEF};
    cdb[1]  = '{is_valid: 1'b1, dest_tag: 6'd10, result: 32'hCAFE};
    rs_we   = 2'b01;
    tick();
    idle_inputs();
    check("bypass_valid", 128'(issue_valid), 128'(1'b1));
    check("bypass_a", 128'(issue_inst.src_0_a.data), 128'(32'hBEEF));
    check("bypass_b", 128'(issue_inst.src_0_b.data), 128'(32'hCAFE));
    tick();

    // Fill all entries with waiting instructions, then wake entry 3
    issue_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      port[0] = mk_inst(8'h50 + 2 * c, mk_op(1, 20 + 2 * c, 0), mk_op(0, 0, 0));
      port[1] = mk_inst(8'h51 + 2 * c, mk_op(1, 21 + 2 * c, 0), mk_op(0, 0, 0));
      rs_we   = 2'b11;
      tick();
    end
    idle_inputs();
    check("full_rdy", 128'(rs_rdy), 128'(2'b00));
    check("full_none_ready", 128'(issue_valid), 128'(1'b0));
    cdb[0] = '{is_valid: 1'b1, dest_tag: 6'd23, result: 32'h77};
    tick();
    idle_inputs();
    check("full_wake_opc", 128'(issue_inst.opcode), 128'(8'h53));
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    check("after_issue_rdy", 128'(rs_rdy), 128'(2'b01));
    port[0] = mk_inst(8'h60, mk_op(0, 0, 32'h60), mk_op(0, 0, 32'h61));
    rs_we   = 2'b01;
    tick();
    idle_inputs();
    check("refill_rdy", 128'(rs_rdy), 128'(2'b00));
    check("refill_opc", 128'(issue_inst.opcode), 128'(8'h60));
    flush = 1'b1;
    tick();
    idle_inputs();
    check("flush_full_rdy", 128'(rs_rdy), 128'(2'b11));

    // Older entry becomes ready while the younger one waits for acceptance
    port[0] = mk_inst(8'h70, mk_op(1, 30, 0), mk_op(0, 0, 0));
    port[1] = mk_inst(8'h71, mk_op(0, 0, 0), mk_op(0, 0, 0));
    rs_we   = 2'b11;
    tick();
    idle_inputs();
    check("age_young_first", 128'(issue_inst.opcode), 128'(8'h71));
    cdb[0] = '{is_valid: 1'b1, dest_tag: 6'd30, result: 32'h5};
    tick();
    idle_inputs();
    check("age_switch", 128'(issue_inst.opcode), 128'(8'h70));
    issue_rdy = 1'b1;
    tick();
    check("age_then_young", 128'(issue_inst.opcode), 128'(8'h71));
    tick();
    issue_rdy = 1'b0;

    // Flush overrides same-cycle writes
    for (int c = 0; c < 2; c++) begin
      port[0] = mk_inst(8'h80 + c, mk_op(1, 40 + c, 0), mk_op(0, 0, 0));
      port[1] = mk_inst(8'h90 + c, mk_op(1, 42 + c, 0), mk_op(0, 0, 0));
      rs_we   = 2'b11;
      tick();
    end
    port[0] = mk_inst(8'hA0, mk_op(0, 0, 0), mk_op(0, 0, 0));
    port[1] = mk_inst(8'hA1, mk_op(0, 0, 0), mk_op(0, 0, 0));
    rs_we   = 2'b11;
    flush   = 1'b1;
    tick();
    idle_inputs();
    check("flush_valid", 128'(issue_valid), 128'(1'b0));
    check("flush_rdy", 128'(rs_rdy), 128'(2'b11));
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      flush     = ($urandom_range(0, 49) == 0);
      issue_rdy = ($urandom_range(0, 9) < 7);
      we        = $urandom_range(0, 3);
      if (!rs_rdy[0]) we = 0;
      else if (!rs_rdy[1] && we == 3) we = $urandom_range(1, 2);
      rs_we = 2'(we);
      for (int k = 0; k < PIPE_WIDTH; k++) port[k] = rand_inst();
      t0 = $urandom_range(0, 15);
      cdb[0] = '{is_valid: $urandom_range(0, 1) == 1, dest_tag: 6'(t0), result: $urandom};
      cdb[1] = '{is_valid: $urandom_range(0, 1) == 1,
                 dest_tag: 6'((t0 + $urandom_range(1, 15)) % 16), result: $urandom};
      tick();
    end

    // Asynchronous reset while an entry is offered for issue
    idle_inputs();
    issue_rdy = 1'b0;
    flush     = 1'b1;
    tick();
    idle_inputs();
    port[0] = mk_inst(8'h99, mk_op(0, 0, 32'h9), mk_op(0, 0, 32'h9));
    rs_we   = 2'b01;
    tick();
    idle_inputs();
    check("pre_rst_valid", 128'(issue_valid), 128'(1'b1));
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(issue_valid), 128'(1'b0));
    check("async_rst_inst", 128'(issue_inst), 128'(0));
    check("async_rst_rdy", 128'(rs_rdy), 128'(2'b11));
    model_reset();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
